// File: rtl/sample_ring_ram.sv
// Multi-channel circular sample buffer used as the FIR tap delay line.
// Reads are addressed by tap offset from the newest sample, with a 1-cycle registered result.
module sample_ring_ram #(
    parameter int unsigned DWIDTH   = 8,
    parameter int unsigned AWIDTH   = 8,
    parameter int unsigned CHW      = 1,
    parameter bit          WR_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [CHW-1:0]    wr_ch,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              clr_en,
    input  logic [CHW-1:0]    clr_ch,
    input  logic              rd_en,
    input  logic [CHW-1:0]    rd_ch,
    input  logic [AWIDTH-1:0] rd_tap,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic              tap_ok
);

    localparam int unsigned DEPTH = 1 << AWIDTH;
    localparam int unsigned NCH   = 1 << CHW;
    localparam int unsigned CW    = AWIDTH + 1;

    logic [DWIDTH-1:0] mem [NCH*DEPTH];

    logic [AWIDTH-1:0] wp_q  [NCH];
    logic [AWIDTH-1:0] wp_d  [NCH];
    logic [CW-1:0]     cnt_q [NCH];
    logic [CW-1:0]     cnt_d [NCH];
    logic [DWIDTH-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              tap_ok_q, tap_ok_d;

    logic              wr_acc;
    logic              fwd;
    logic [AWIDTH-1:0] rd_wp;
    logic [CW-1:0]     rd_cnt;
    logic [CW-1:0]     rd_cnt_eff;
    logic [AWIDTH-1:0] rd_ptr;
    logic [DWIDTH-1:0] rd_word;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CW'(DEPTH)) ? c : c + CW'(1);
    endfunction

    // A clear on the write's own channel wins over the write.
    assign wr_acc     = wr_en && !(clr_en && (clr_ch == wr_ch));
    assign fwd        = WR_FIRST && wr_acc && (wr_ch == rd_ch);
    assign rd_wp      = wp_q[rd_ch];
    assign rd_cnt     = cnt_q[rd_ch];
    assign rd_cnt_eff = fwd ? sat_inc(rd_cnt) : rd_cnt;
    assign rd_ptr     = fwd ? (rd_wp - rd_tap) : (rd_wp - rd_tap - AWIDTH'(1));
    assign rd_word    = mem[{rd_ch, rd_ptr}];

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            wp_d[i]  = wp_q[i];
            cnt_d[i] = cnt_q[i];
        end
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        tap_ok_d   = tap_ok_q;

        if (wr_acc) begin
            wp_d[wr_ch]  = wp_q[wr_ch] + AWIDTH'(1);
            cnt_d[wr_ch] = sat_inc(cnt_q[wr_ch]);
        end
        if (clr_en) begin
            wp_d[clr_ch]  = '0;
            cnt_d[clr_ch] = '0;
        end

        if (rd_en) begin
            rd_data_d = (fwd && (rd_tap == '0)) ? wr_data : rd_word;
            tap_ok_d  = ({1'b0, rd_tap} < rd_cnt_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                wp_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            tap_ok_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                wp_q[i]  <= wp_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            tap_ok_q   <= tap_ok_d;
        end
    end

    // Sample storage is never reset; only the pointers are.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[{wr_ch, wp_q[wr_ch]}] <= wr_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign tap_ok   = tap_ok_q;

endmodule
